// File: rtl/alu_pc_unit_if.sv
// Bus bundle between the pipeline control/datapath and alu_pc_unit.
// The master drives PC-mux selection and ALU operands; the slave returns
// the registered PC, its increment, and the ALU result/flags.
interface alu_pc_unit_if #(
  parameter int unsigned PCSIZE = 16
);
  logic [PCSIZE-1:0] pc_next;
  logic              pc_write;
  logic [PCSIZE-1:0] pc;
  logic [PCSIZE-1:0] pc_plus4;
  logic [4:0]        aluop;
  logic              sign;
  logic [31:0]       op1;
  logic [31:0]       op2;
  logic [31:0]       result;
  logic              zero;
  logic              neg;

  modport master (
    output pc_next, pc_write, aluop, sign, op1, op2,
    input  pc, pc_plus4, result, zero, neg
  );

  modport slave (
    input  pc_next, pc_write, aluop, sign, op1, op2,
    output pc, pc_plus4, result, zero, neg
  );
endinterface

// File: rtl/alu_pc_unit.sv
// Execute-stage 32-bit ALU (combinational, with zero/less-than flags)
// plus fetch-stage PC register with stall enable and PC+4 incrementer.
module alu_pc_unit #(
  parameter int unsigned PCSIZE = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_pc_unit_if.slave  bus
);

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_SLL   = 5'd2,
    OP_SLT   = 5'd3,
    OP_SLTU  = 5'd4,
    OP_XOR   = 5'd5,
    OP_SRL   = 5'd6,
    OP_SRA   = 5'd7,
    OP_OR    = 5'd8,
    OP_AND   = 5'd9,
    OP_PASSB = 5'd10,
    OP_MUL   = 5'd11,
    OP_MULH  = 5'd12,
    OP_MULHU = 5'd13
  } aluop_e;

  aluop_e            op;
  logic [4:0]        shamt;
  logic              lt_s;
  logic              lt_u;
  logic [63:0]       prod_u;
  logic [31:0]       mulh;
  logic [31:0]       res;
  logic [PCSIZE-1:0] pc_q;

  assign op     = aluop_e'(bus.aluop);
  assign shamt  = bus.op2[4:0];
  assign lt_s   = $signed(bus.op1) < $signed(bus.op2);
  assign lt_u   = bus.op1 < bus.op2;
  assign prod_u = {32'b0, bus.op1} * {32'b0, bus.op2};

  // Signed high word derived from the single unsigned product:
  // subtract each operand wherever the other one is negative (mod 2^32).
  assign mulh = prod_u[63:32]
              - (bus.op1[31] ? bus.op2 : 32'h0)
              - (bus.op2[31] ? bus.op1 : 32'h0);

  // ALU operation select; undefined codes yield zero.
  always_comb begin
    res = '0;
    case (op)
      OP_ADD:   res = bus.op1 + bus.op2;
      OP_SUB:   res = bus.op1 - bus.op2;
      OP_SLL:   res = bus.op1 << shamt;
      OP_SLT:   res = {31'b0, lt_s};
      OP_SLTU:  res = {31'b0, lt_u};
      OP_XOR:   res = bus.op1 ^ bus.op2;
      OP_SRL:   res = bus.op1 >> shamt;
      OP_SRA:   res = 32'($signed(bus.op1) >>> shamt);
      OP_OR:    res = bus.op1 | bus.op2;
      OP_AND:   res = bus.op1 & bus.op2;
      OP_PASSB: res = bus.op2;
      OP_MUL:   res = prod_u[31:0];
      OP_MULH:  res = mulh;
      OP_MULHU: res = prod_u[63:32];
      default:  res = '0;
    endcase
  end

  assign bus.result = res;
  assign bus.zero   = (res == 32'h0);
  assign bus.neg    = bus.sign ? lt_s : lt_u;

  // PC register: async clear, load on pc_write, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else if (bus.pc_write) begin
      pc_q <= bus.pc_next;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_q + PCSIZE'(4);

endmodule

// File: tb/tb_alu_pc_unit.sv
// Self-checking bench for alu_pc_unit: directed literal checks from the
// test plan, then randomized traffic compared each cycle to a reference model.
module tb_alu_pc_unit;

  localparam int unsigned PCSIZE = 16;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   total;
  int   bad;
  logic [PCSIZE-1:0] mpc;

  alu_pc_unit_if #(.PCSIZE(PCSIZE)) bus ();

  alu_pc_unit #(.PCSIZE(PCSIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    int              sh;
    longint unsigned r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    sh = int'(b % 32);
    case (op)
      0:  r = ua + ub;
      1:  r = ua - ub;
      2:  r = ua << sh;
      3:  r = (sa < sb) ? 1 : 0;
      4:  r = (ua < ub) ? 1 : 0;
      5:  r = ua ^ ub;
      6:  r = ua >> sh;
      7:  r = longint'(sa >>> sh);
      8:  r = ua | ub;
      9:  r = ua & ub;
      10: r = ub;
      11: r = ua * ub;
      12: r = longint'((sa * sb) >>> 32);
      13: r = (ua * ub) >> 32;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic ref_neg(input logic s, input logic [31:0] a,
                                   input logic [31:0] b);
    if (s) return longint'($signed(a)) < longint'($signed(b));
    return 64'(a) < 64'(b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference PC register.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mpc <= '0;
    else if (bus.pc_write) mpc <= bus.pc_next;
  end

  // Per-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0]       er;
      logic [PCSIZE-1:0] ep4;
      er  = ref_alu(int'(bus.aluop), bus.op1, bus.op2);
      ep4 = mpc + PCSIZE'(4);
      chk("cyc_result", bus.result, er);
      chk("cyc_zero", 32'(bus.zero), 32'(er == 32'h0));
      chk("cyc_neg", 32'(bus.neg), 32'(ref_neg(bus.sign, bus.op1, bus.op2)));
      chk("cyc_pc", 32'(bus.pc), 32'(mpc));
      chk("cyc_pc_plus4", 32'(bus.pc_plus4), 32'(ep4));
    end
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_dir(input string name, input int op, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_zero);
    bus.aluop = 5'(op);
    bus.sign  = s;
    bus.op1   = a;
    bus.op2   = b;
    #1;
    chk({name, "_res"}, bus.result, exp_res);
    chk({name, "_zero"}, 32'(bus.zero), 32'(exp_zero));
    chk({name, "_model"}, ref_alu(op, a, b), exp_res);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    chk_en = 1'b0;
    mpc   = '0;
    rst_n = 1'b0;
    bus.pc_next  = '0;
    bus.pc_write = 1'b0;
    bus.aluop    = '0;
    bus.sign     = 1'b0;
    bus.op1      = '0;
    bus.op2      = '0;
    #2;
    chk("reset_pc", 32'(bus.pc), 32'h0);
    chk("reset_pc_plus4", 32'(bus.pc_plus4), 32'h4);
    repeat (2) edge_step();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Reset mid-run and stall behaviour.
    bus.pc_write = 1'b1;
    bus.pc_next  = 16'h0040;
    edge_step();
    chk("load_0040", 32'(bus.pc), 32'h0040);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", 32'(bus.pc), 32'h0);
    chk("async_rst_pc_plus4", 32'(bus.pc_plus4), 32'h4);
    bus.pc_next = 16'h0100;
    edge_step();
    chk("edge_in_reset", 32'(bus.pc), 32'h0);
    rst_n = 1'b1;
    bus.pc_write = 1'b0;
    repeat (3) edge_step();
    chk("stall_pc", 32'(bus.pc), 32'h0);
    chk("stall_pc_plus4", 32'(bus.pc_plus4), 32'h4);
    bus.pc_write = 1'b1;
    edge_step();
    chk("load_0100", 32'(bus.pc), 32'h0100);
    chk("load_0100_plus4", 32'(bus.pc_plus4), 32'h0104);
    bus.pc_next = 16'hFFFC;
    edge_step();
    chk("wrap_pc", 32'(bus.pc), 32'hFFFC);
    chk("wrap_pc_plus4", 32'(bus.pc_plus4), 32'h0000);

    // Directed ALU vectors.
    alu_dir("add_ovf", 0, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0);
    alu_dir("sub_eq", 1, 1'b0, 32'h5, 32'h5, 32'h0, 1'b1);
    alu_dir("add_wrap", 0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1);
    alu_dir("slt", 3, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0);
    chk("neg_signed", 32'(bus.neg), 32'h1);
    alu_dir("sltu", 4, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1);
    chk("neg_unsigned", 32'(bus.neg), 32'h0);
    alu_dir("sra", 7, 1'b0, 32'h80000000, 32'h24, 32'hF8000000, 1'b0);
    alu_dir("srl", 6, 1'b0, 32'h80000000, 32'h24, 32'h08000000, 1'b0);
    alu_dir("sll", 2, 1'b0, 32'h1, 32'h24, 32'h10, 1'b0);
    alu_dir("and", 9, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0);
    alu_dir("or", 8, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0);
    alu_dir("xor", 5, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0);
    alu_dir("passb", 10, 1'b0, 32'h12345678, 32'hABCDE000, 32'hABCDE000, 1'b0);
    alu_dir("mul", 11, 1'b0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1'b0);
    alu_dir("mulh", 12, 1'b0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 1'b0);
    alu_dir("mulhu", 13, 1'b0, 32'hFFFFFFFF, 32'h2, 32'h00000001, 1'b0);
    alu_dir("mulh_neg", 12, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    alu_dir("undef20", 20, 1'b0, 32'hDEADBEEF, 32'h1, 32'h0, 1'b1);

    // Randomized traffic with occasional stalls and resets.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      rst_n        = ($urandom_range(0, 40) != 0);
      bus.pc_write = $urandom_range(0, 3) != 0;
      bus.pc_next  = ($urandom_range(0, 9) == 0) ? 16'hFFFC : 16'($urandom);
      bus.aluop    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(14, 31))
                                                 : 5'($urandom_range(0, 13));
      bus.sign     = 1'($urandom);
      case ($urandom_range(0, 4))
        0: bus.op1 = 32'h80000000;
        1: bus.op1 = 32'hFFFFFFFF;
        default: bus.op1 = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: bus.op2 = bus.op1;
        1: bus.op2 = 32'h7FFFFFFF;
        default: bus.op2 = $urandom;
      endcase
    end
    edge_step();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
